i2s_audio_recorder: RTL and testbench
=====================================

Name: i2s_audio_recorder

Overview:
- Capture-side counterpart of the speaker playback path: I2S master receiver for the codec ADC (e.g. Pmod I2S2 line-in).
- Generates mclk/lrck/sck and deserializes 16-bit left/right samples from sdout.
- Decimates to roughly 8 kHz mono and writes 8-bit samples into a single-port block RAM (17-bit address, 8-bit data).
- The existing playback path reads that RAM back out.

Parameters:
ADDR_SIZE, 6458, number of 8-bit samples stored per recording (1..131072)
DECIM, 24, frames per stored sample (1..255); 100 MHz/512/24 ≈ 8.1 kHz

Ports:
clk  input  1  100 MHz system clock
rst  input  1  asynchronous active-low reset
rec  input  1  start/restart recording (sync, one-pulse)
stop  input  1  abort recording (sync, one-pulse)
sdout  input  1  serial ADC data from codec
mclk  output  1  master clock, clk/4
lrck  output  1  word select, clk/512
sck  output  1  serial bit clock, clk/16
sample_left  output  16  last complete left sample
sample_right  output  16  last complete right sample
sample_valid  output  1  one-cycle pulse, new sample pair
mem_we  output  1  RAM write strobe
mem_addr  output  17  RAM write address
mem_din  output  8  RAM write data
busy  output  1  recording in progress
done  output  1  sticky: last recording completed fully

Behaviour:
- Reset (rst=0, asynchronous): all registers clear. Every output reads 0. FSM goes to IDLE.
- Clock generation:
  - cnt is a 9-bit free-running counter.
  - mclk=cnt[1], sck=cnt[3], lrck=cnt[8].
  - slot=cnt[8:4]. There are 32 slots per frame, 16 clk per slot.
- Input capture:
  - sdout passes through a 2-flop synchronizer (reset 0).
  - The synchronized bit is captured on the clk edge where cnt[3:0]==10. This is mid sck-high, so a 2-cycle synchronizer delay is safe.
- Framing (I2S, one-bit delay):
  - Slot 0 carries right[0] of the previous frame.
  - Slots 1..16 carry left[15:0], MSB first.
  - Slots 17..31 carry right[15:1].
- Deserializer and sample outputs:
  - A 32-bit shift register takes new bits at bit 0.
  - On a capture in slot 0, the 32 most recent bits (including this one) are split as sample_left={bits[31:16]} and sample_right={bits[15:0]}.
  - The sample registers update and sample_valid pulses on the cycle after that capture edge.
- First frame after reset: the first slot-0 capture sets a primed flag but produces no sample_valid. The first valid pulse comes 512 clk later.
- Mono mix:
  - sum = sign-extended left + right, 17 bits.
  - mem_din = sum[16:9], which is the arithmetic average's top byte.
  - The mix is registered together with the write.
- FSM: IDLE, REC.
  - IDLE, rec=1: mem_addr←0, decim←0, done←0, go to REC.
  - REC, each sample_valid: if decim==DECIM-1 then decim←0 and a write is issued; otherwise decim+1.
  - A write asserts mem_we high for exactly 1 cycle, the cycle after the triggering sample_valid.
  - mem_addr and mem_din are stable during mem_we.
  - After each write: if mem_addr==ADDR_SIZE-1, go to IDLE and set done←1, with mem_addr held. Otherwise mem_addr increments on the following cycle.
  - REC, rec=1: restart (mem_addr←0, decim←0), stay in REC. Any write pending that cycle is dropped.
  - REC, stop=1: go to IDLE, done stays 0, mem_addr holds, no further mem_we.
  - rec and stop in the same cycle: stop wins.
  - IDLE, stop: ignored.
- busy = (state==REC), registered.
- The deserializer and sample outputs run continuously regardless of FSM state.
- Reset asserted mid-operation: busy, mem_we, done, cnt and all outputs go to 0 immediately.

Test Plan:
1. Reset: hold rst=0 for 5 cycles, then release → outputs 0 during reset; lrck first rises 256 clk after release; sck period 16 clk; mclk period 4 clk.
2. Deserializer: codec model drives left=16'hA5C3, right=16'h1234 every frame → no sample_valid on the first slot-0 capture; thereafter sample_valid every 512 clk with sample_left=A5C3, sample_right=1234.
3. Mono mix:
   - left=right=16'h7FFF → mem_din=8'h7F.
   - left=right=16'h8000 → 8'h80.
   - left=16'h7FFF, right=16'h8001 → 8'h00.
4. Full recording, ADDR_SIZE=4, DECIM=2: pulse rec → exactly 4 single-cycle mem_we at mem_addr 0,1,2,3, spaced 1024 clk; then busy=0, done=1, no further writes.
5. Abort and restart: stop after 2 writes → busy=0, done=0, mem_addr=1, no writes. rec again → next write at addr 0. rec+stop in the same cycle during REC → IDLE.
6. Async reset mid-REC: drop rst between clk edges → busy, mem_we, done, mem_addr and cnt read 0 before the next edge; no writes after release until rec.

Source files
------------

// File: rtl/i2s_audio_recorder.sv
// I2S master receiver for the codec ADC: generates mclk/lrck/sck, deserializes
// 16-bit stereo samples and records a decimated 8-bit mono mix into block RAM.
//
// state  | meaning
// S_IDLE | not recording; mem_addr holds last written address
// S_REC  | recording; every DECIM-th sample pair is written to RAM
module i2s_audio_recorder #(
  parameter int ADDR_SIZE = 6458,
  parameter int DECIM     = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec,
  input  logic        stop,
  input  logic        sdout,
  output logic        mclk,
  output logic        lrck,
  output logic        sck,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0]  S_IDLE     = 1'b0;
  localparam logic [0:0]  S_REC      = 1'b1;
  localparam logic [7:0]  DECIM_LAST = 8'(DECIM - 1);
  localparam logic [16:0] ADDR_LAST  = 17'(ADDR_SIZE - 1);

  logic [8:0]  cnt;
  logic        sync1;
  logic        sync2;
  logic [31:0] shreg;
  logic [31:0] shreg_next;
  logic        primed;
  logic        capture;
  logic        slot0;
  logic [16:0] mix_sum;
  logic [0:0]  state;
  logic [7:0]  decim;

  assign mclk       = cnt[1];
  assign sck        = cnt[3];
  assign lrck       = cnt[8];
  assign capture    = (cnt[3:0] == 4'd10);
  assign slot0      = (cnt[8:4] == 5'd0);
  assign shreg_next = {shreg[30:0], sync2};
  assign mix_sum    = {sample_left[15], sample_left} + {sample_right[15], sample_right};
  assign busy       = (state == S_REC);

  // Capture lands mid sck-high, so the two synchronizer cycles stay inside the bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      shreg        <= '0;
      primed       <= 1'b0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
    end else begin
      cnt          <= cnt + 9'd1;
      sync1        <= sdout;
      sync2        <= sync1;
      sample_valid <= 1'b0;
      if (capture) begin
        shreg <= shreg_next;
        if (slot0) begin
          primed <= 1'b1;
          if (primed) begin
            sample_left  <= shreg_next[31:16];
            sample_right <= shreg_next[15:0];
            sample_valid <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      decim    <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rec) begin
            mem_addr <= '0;
            decim    <= '0;
            done     <= 1'b0;
            state    <= S_REC;
          end
        end
        S_REC: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (rec) begin
            mem_addr <= '0;
            decim    <= '0;
          end else begin
            // Address advances only once the write cycle has completed.
            if (mem_we) begin
              if (mem_addr == ADDR_LAST) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                mem_addr <= mem_addr + 17'd1;
              end
            end
            if (sample_valid) begin
              if (decim == DECIM_LAST) begin
                decim   <= '0;
                mem_we  <= 1'b1;
                mem_din <= mix_sum[16:9];
              end else begin
                decim <= decim + 8'd1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_audio_recorder.sv
// Directed bench for i2s_audio_recorder: codec model driving sdout, clock
// checks, deserializer, mono mix table, full/aborted recordings and async reset.
module tb_i2s_audio_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rec = 1'b0;
  logic        stop = 1'b0;
  logic        sdout = 1'b0;
  logic        mclk, lrck, sck;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, mem_we, busy, done;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] left_v = 16'hA5C3;
  logic [15:0] right_v = 16'h1234;
  logic [8:0]  tb_cnt;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [7:0]  din;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  i2s_audio_recorder #(.ADDR_SIZE(4), .DECIM(2)) dut (
    .clk(clk), .rst(rst), .rec(rec), .stop(stop), .sdout(sdout),
    .mclk(mclk), .lrck(lrck), .sck(sck),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .busy(busy), .done(done)
  );

  // Codec model: frame position tracked from reset release, bit held for a whole slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tb_cnt <= '0;
    else      tb_cnt <= tb_cnt + 9'd1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic frame_bit(input logic [4:0] s, input logic [15:0] l,
                                     input logic [15:0] r);
    int si;
    si = int'(s);
    if (si == 0) return r[0];
    if (si <= 16) return l[4'(16 - si)];
    return r[4'(32 - si)];
  endfunction

  always @(negedge clk) sdout = frame_bit(tb_cnt[8:4], left_v, right_v);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_rec();
    @(negedge clk) rec = 1'b1;
    @(negedge clk) rec = 1'b0;
  endtask

  task automatic wait_we(output logic [16:0] a, output logic [7:0] d,
                         output int t, output bit ok);
    ok = 1'b0; a = '0; d = '0; t = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (mem_we) begin
        a = mem_addr; d = mem_din; t = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_we(input int n, output int cnt_o);
    cnt_o = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mem_we) cnt_o++;
    end
  endtask

  initial begin
    logic [16:0] a;
    logic [7:0]  d;
    int t, t_prev, nw, n;
    bit ok, prev_we;
    int mclk_r1, mclk_r2, sck_r1, sck_r2, lrck_r1, v1, v2, nvalid;
    logic pm, ps, pl;

    vecs[0] = '{16'h7FFF, 16'h7FFF, 8'h7F};
    vecs[1] = '{16'h8000, 16'h8000, 8'h80};
    vecs[2] = '{16'h7FFF, 16'h8001, 8'h00};
    vecs[3] = '{16'hA5C3, 16'h1234, 8'hDB};
    vecs[4] = '{16'h0001, 16'h0000, 8'h00};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 8'hFF};

    // Reset held, then release
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {25'd0, mclk, lrck, sck, sample_valid, mem_we, busy, done}, 32'd0);
    chk("rst_addr", {15'd0, mem_addr}, 32'd0);
    chk("rst_samples", {sample_left, sample_right}, 32'd0);
    chk("rst_din", {24'd0, mem_din}, 32'd0);
    rst = 1'b1;

    mclk_r1 = -1; mclk_r2 = -1; sck_r1 = -1; sck_r2 = -1; lrck_r1 = -1;
    v1 = -1; v2 = -1; nvalid = 0;
    pm = 1'b0; ps = 1'b0; pl = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk);
      #1;
      if (mclk && !pm) begin if (mclk_r1 < 0) mclk_r1 = k; else if (mclk_r2 < 0) mclk_r2 = k; end
      if (sck && !ps) begin if (sck_r1 < 0) sck_r1 = k; else if (sck_r2 < 0) sck_r2 = k; end
      if (lrck && !pl && lrck_r1 < 0) lrck_r1 = k;
      pm = mclk; ps = sck; pl = lrck;
      if (sample_valid) begin
        nvalid++;
        if (v1 < 0) v1 = k; else if (v2 < 0) v2 = k;
        chk("deser_left", {16'd0, sample_left}, 32'h0000A5C3);
        chk("deser_right", {16'd0, sample_right}, 32'h00001234);
      end
    end
    chk("lrck_first_rise", lrck_r1, 256);
    chk("mclk_period", mclk_r2 - mclk_r1, 4);
    chk("sck_period", sck_r2 - sck_r1, 16);
    chk("valid_first", v1, 523);
    chk("valid_period", v2 - v1, 512);
    chk("valid_count", nvalid, 2);

    // Mono mix table
    for (int i = 0; i < 6; i++) begin
      left_v = vecs[i].l;
      right_v = vecs[i].r;
      repeat (1600) @(negedge clk);
      pulse_rec();
      wait_we(a, d, t, ok);
      chk("mix_we_seen", {31'd0, ok}, 32'd1);
      chk("mix_left", {16'd0, sample_left}, {16'd0, vecs[i].l});
      chk("mix_right", {16'd0, sample_right}, {16'd0, vecs[i].r});
      chk("mix_din", {24'd0, d}, {24'd0, vecs[i].din});
      chk("mix_addr", {15'd0, a}, 32'd0);
      @(negedge clk) stop = 1'b1;
      @(negedge clk) stop = 1'b0;
      chk("mix_stop_busy", {31'd0, busy}, 32'd0);
    end

    // Full recording: 4 writes spaced 1024 clk
    pulse_rec();
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_done_clr", {31'd0, done}, 32'd0);
    nw = 0; t_prev = 0; prev_we = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (mem_we) begin
        chk("we_single", {31'd0, prev_we}, 32'd0);
        if (nw < 4) chk("full_addr", {15'd0, mem_addr}, nw);
        if (nw > 0) chk("full_spacing", cyc - t_prev, 1024);
        t_prev = cyc;
        nw++;
      end
      prev_we = mem_we;
    end
    chk("full_writes", nw, 4);
    chk("full_end_busy", {31'd0, busy}, 32'd0);
    chk("full_end_done", {31'd0, done}, 32'd1);
    chk("full_end_addr", {15'd0, mem_addr}, 32'd3);

    // Async reset clears sticky done
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk) rst = 1'b1;

    // Abort during second write, then restart
    pulse_rec();
    wait_we(a, d, t, ok);
    chk("abort_w1", {14'd0, ok, a}, {14'd0, 1'b1, 17'd0});
    wait_we(a, d, t, ok);
    chk("abort_w2", {14'd0, ok, a}, {14'd0, 1'b1, 17'd1});
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_addr", {15'd0, mem_addr}, 32'd1);
    count_we(2500, n);
    chk("abort_no_writes", n, 0);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    chk("idle_stop_ignored", {31'd0, busy}, 32'd0);
    pulse_rec();
    wait_we(a, d, t, ok);
    chk("restart_addr", {14'd0, ok, a}, {14'd0, 1'b1, 17'd0});
    @(negedge clk) begin rec = 1'b1; stop = 1'b1; end
    @(negedge clk) begin rec = 1'b0; stop = 1'b0; end
    chk("recstop_busy", {31'd0, busy}, 32'd0);
    chk("recstop_addr", {15'd0, mem_addr}, 32'd1);
    count_we(1200, n);
    chk("recstop_no_writes", n, 0);

    // Async reset in the middle of a write cycle
    pulse_rec();
    wait_we(a, d, t, ok);
    wait_we(a, d, t, ok);
    chk("arst_pre", {14'd0, ok, a}, {14'd0, 1'b1, 17'd1});
    #2 rst = 1'b0;
    #1;
    chk("arst_ctl", {28'd0, busy, mem_we, done, sample_valid}, 32'd0);
    chk("arst_addr", {15'd0, mem_addr}, 32'd0);
    chk("arst_clocks", {29'd0, mclk, sck, lrck}, 32'd0);
    chk("arst_data", {8'd0, mem_din, sample_left}, 32'd0);
    @(negedge clk) rst = 1'b1;
    count_we(3000, n);
    chk("arst_no_writes", n, 0);
    chk("arst_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
